// File: rtl/osc_period_meter.sv
// osc_period_meter: measures the period of a signed oscillator sample stream.
// A rising crossing is a LOW sample (<= -H) followed by a HIGH sample (>= +H).
// The distance in clk cycles between successive rising crossings is reported.
//
// state        | meaning
// -------------+------------------------------------------------------------
// IDLE_E       | disabled, counter held at zero
// SYNC_LOW_E   | hunting for the first LOW sample
// SYNC_HIGH_E  | hunting for the first HIGH sample (first edge, no report)
// MEAS_LOW_E   | counting, waiting for a LOW sample
// MEAS_HIGH_E  | counting, waiting for a HIGH sample (edge, period reported)
module osc_period_meter #(
  parameter int SAMPLE_WIDTH_P  = 24,
  parameter int COUNTER_WIDTH_P = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       sample_valid,
  input  logic [SAMPLE_WIDTH_P-1:0]  sample_data,
  input  logic                       cr_enable,
  input  logic [SAMPLE_WIDTH_P-2:0]  cr_hysteresis,
  output logic [COUNTER_WIDTH_P-1:0] period,
  output logic                       period_valid,
  output logic                       sr_locked,
  output logic                       sr_timeout
);

  localparam logic [2:0] IDLE_E      = 3'd0;
  localparam logic [2:0] SYNC_LOW_E  = 3'd1;
  localparam logic [2:0] SYNC_HIGH_E = 3'd2;
  localparam logic [2:0] MEAS_LOW_E  = 3'd3;
  localparam logic [2:0] MEAS_HIGH_E = 3'd4;

  localparam logic [COUNTER_WIDTH_P-1:0] CNT_ZERO = '0;
  localparam logic [COUNTER_WIDTH_P-1:0] CNT_MAX  = '1;
  localparam logic [COUNTER_WIDTH_P-1:0] CNT_ONE  = {{(COUNTER_WIDTH_P-1){1'b0}}, 1'b1};

  logic [2:0]                 state;
  logic [COUNTER_WIDTH_P-1:0] counter;

  // One extra bit keeps -H representable for the largest threshold.
  logic signed [SAMPLE_WIDTH_P:0] sample_ext;
  logic signed [SAMPLE_WIDTH_P:0] hyst_pos;
  logic signed [SAMPLE_WIDTH_P:0] hyst_neg;
  logic                           is_low;
  logic                           is_high;
  logic                           cnt_sat;

  assign sample_ext = {sample_data[SAMPLE_WIDTH_P-1], sample_data};
  assign hyst_pos   = {2'b00, cr_hysteresis};
  assign hyst_neg   = -hyst_pos;
  assign is_low     = sample_valid && (sample_ext <= hyst_neg);
  assign is_high    = sample_valid && (sample_ext >= hyst_pos);
  assign cnt_sat    = (counter == CNT_MAX);

  // Crossing FSM, period counter and registered status outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE_E;
      counter      <= CNT_ZERO;
      period       <= CNT_ZERO;
      period_valid <= 1'b0;
      sr_locked    <= 1'b0;
      sr_timeout   <= 1'b0;
    end else begin
      period_valid <= 1'b0;
      if (!cr_enable) begin
        // Disable wins over any edge seen on the same cycle; period holds.
        state      <= IDLE_E;
        counter    <= CNT_ZERO;
        sr_locked  <= 1'b0;
        sr_timeout <= 1'b0;
      end else begin
        case (state)
          IDLE_E: begin
            counter <= CNT_ZERO;
            state   <= SYNC_LOW_E;
          end
          SYNC_LOW_E: begin
            if (is_low) state <= SYNC_HIGH_E;
          end
          SYNC_HIGH_E: begin
            if (is_high) begin
              counter <= CNT_ONE;
              state   <= MEAS_LOW_E;
            end
          end
          MEAS_LOW_E: begin
            if (cnt_sat) begin
              sr_timeout <= 1'b1;
              sr_locked  <= 1'b0;
              counter    <= CNT_ZERO;
              state      <= SYNC_LOW_E;
            end else begin
              counter <= counter + CNT_ONE;
              if (is_low) state <= MEAS_HIGH_E;
            end
          end
          MEAS_HIGH_E: begin
            if (is_high) begin
              // An edge on the saturating cycle still reports all-ones.
              period       <= counter;
              period_valid <= 1'b1;
              sr_locked    <= 1'b1;
              sr_timeout   <= 1'b0;
              counter      <= CNT_ONE;
              state        <= MEAS_LOW_E;
            end else if (cnt_sat) begin
              sr_timeout <= 1'b1;
              sr_locked  <= 1'b0;
              counter    <= CNT_ZERO;
              state      <= SYNC_LOW_E;
            end else begin
              counter <= counter + CNT_ONE;
            end
          end
          default: begin
            counter <= CNT_ZERO;
            state   <= IDLE_E;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_osc_period_meter.sv
// Testbench for osc_period_meter: directed scenarios plus randomized square
// waves, checked against a timestamp-based crossing model and a period queue.
module tb_osc_period_meter;

  localparam int SW   = 24;
  localparam int CW   = 8;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          sample_valid = 1'b0;
  logic [SW-1:0] sample_data = '0;
  logic          cr_enable = 1'b0;
  logic [SW-2:0] cr_hysteresis = '0;
  logic [CW-1:0] period;
  logic          period_valid;
  logic          sr_locked;
  logic          sr_timeout;

  osc_period_meter #(.SAMPLE_WIDTH_P(SW), .COUNTER_WIDTH_P(CW)) dut (
    .clk(clk), .rst(rst), .sample_valid(sample_valid), .sample_data(sample_data),
    .cr_enable(cr_enable), .cr_hysteresis(cr_hysteresis), .period(period),
    .period_valid(period_valid), .sr_locked(sr_locked), .sr_timeout(sr_timeout)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int pulses   = 0;
  int exp_q[$];

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: timestamps of crossings rather than a state register.
  bit m_idle, m_have_t0, m_seen_low, m_locked, m_timeout, m_pv;
  int m_t, m_t0, m_period;

  always @(posedge clk) begin
    int s, h, d;
    bit lo, hi;
    m_pv = 1'b0;
    if (rst) begin
      m_idle = 1; m_have_t0 = 0; m_seen_low = 0; m_locked = 0; m_timeout = 0;
      m_period = 0; m_t = 0; m_t0 = 0;
    end else begin
      m_t++;
      s  = $signed(sample_data);
      h  = int'(cr_hysteresis);
      lo = sample_valid && (s <= -h);
      hi = sample_valid && (s >= h);
      if (!cr_enable) begin
        m_idle = 1; m_have_t0 = 0; m_seen_low = 0; m_locked = 0; m_timeout = 0;
      end else if (m_idle) begin
        m_idle = 0; m_have_t0 = 0; m_seen_low = 0;
      end else if (!m_have_t0) begin
        if (!m_seen_low) begin
          if (lo) m_seen_low = 1;
        end else if (hi) begin
          m_have_t0 = 1; m_t0 = m_t; m_seen_low = 0;
        end
      end else begin
        d = m_t - m_t0;
        if (m_seen_low && hi) begin
          exp_q.push_back(d);
          m_pv = 1; m_period = d; m_locked = 1; m_timeout = 0;
          m_t0 = m_t; m_seen_low = 0;
        end else if (d == CMAX) begin
          m_timeout = 1; m_locked = 0; m_have_t0 = 0; m_seen_low = 0;
        end else if (!m_seen_low && lo) begin
          m_seen_low = 1;
        end
      end
    end
  end

  // Monitor: compares registered outputs just after each edge, pops on pulses.
  always begin
    @(posedge clk);
    #1;
    check("period_hold", period, m_period);
    check("period_valid", period_valid, m_pv);
    check("sr_locked", sr_locked, m_locked);
    check("sr_timeout", sr_timeout, m_timeout);
    if (period_valid) begin
      pulses++;
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL pv_unexpected: got pulse with period %0d, expected none", period);
      end else begin
        check("period_value", period, exp_q.pop_front());
      end
    end
  end

  task automatic step(input bit v, input int val);
    @(negedge clk);
    sample_valid = v;
    if (v) sample_data = val[SW-1:0];
    else   sample_data = SW'($urandom);
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 0);
  endtask

  task automatic restart();
    @(negedge clk); cr_enable = 1'b0; sample_valid = 1'b0;
    @(negedge clk); cr_enable = 1'b1;
  endtask

  // Square wave, low half first; dec>1 gives a valid sample every dec cycles.
  task automatic square(input int half, input int periods, input int dec,
                        input int amp, input int noise, input bit rnd_valid);
    for (int p = 0; p < periods; p++)
      for (int lvl = 0; lvl < 2; lvl++)
        for (int i = 0; i < half * dec; i++) begin
          int val;
          bit v;
          val = (lvl == 0) ? -amp : amp;
          if (noise > 0) val += $urandom_range(0, 2 * noise) - noise;
          v = rnd_valid ? ($urandom_range(0, 3) != 0) : ((i % dec) == 0);
          step(v, val);
        end
  endtask

  initial begin
    #900_000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1, "watchdog");
  end

  initial begin
    int p0;
    repeat (3) @(negedge clk);
    check("reset_period", period, 0);
    check("reset_pv", period_valid, 0);
    check("reset_locked", sr_locked, 0);
    check("reset_timeout", sr_timeout, 0);
    rst = 1'b0;

    // Square wave at full rate.
    cr_hysteresis = 100;
    cr_enable = 1'b1;
    square(4, 8, 1, 1000, 0, 0);
    check("sq_full_period", period, 8);
    check("sq_full_locked", sr_locked, 1);

    // Decimated sample rate.
    restart();
    square(4, 6, 4, 1000, 0, 0);
    check("sq_dec_period", period, 32);

    // Noise inside the hysteresis band.
    restart();
    p0 = pulses;
    for (int i = 0; i < 200; i++) step(1'b1, (i % 2) ? 50 : -50);
    check("noise_pulses", pulses, p0);
    check("noise_locked", sr_locked, 0);

    // Counter saturation after a single edge.
    restart();
    for (int i = 0; i < 4; i++) step(1'b1, -1000);
    for (int i = 0; i < 300; i++) step(1'b1, 1000);
    check("sat_timeout", sr_timeout, 1);
    check("sat_locked", sr_locked, 0);
    square(4, 4, 1, 1000, 0, 0);
    check("sat_cleared", sr_timeout, 0);
    check("sat_period", period, 8);

    // Disable for one cycle in the middle of a measurement.
    restart();
    square(4, 4, 1, 1000, 0, 0);
    step(1'b1, -1000); step(1'b1, -1000);
    @(negedge clk); cr_enable = 1'b0; sample_valid = 1'b1; sample_data = SW'(-1000);
    @(negedge clk); cr_enable = 1'b1;
    check("dis_period_hold", period, 8);
    check("dis_locked", sr_locked, 0);
    p0 = pulses;
    square(4, 1, 1, 1000, 0, 0);
    check("dis_no_early_pulse", pulses, p0);
    square(4, 3, 1, 1000, 0, 0);

    // Reset in the middle of a measurement.
    step(1'b1, -1000); step(1'b1, -1000);
    rst = 1'b1;
    @(posedge clk); #1;
    check("rst_period", period, 0);
    check("rst_locked", sr_locked, 0);
    @(negedge clk); rst = 1'b0;

    // H=0 slow ramp, edges land exactly on the zero sample.
    cr_hysteresis = 0;
    restart();
    for (int r = 0; r < 6; r++)
      for (int k = -3; k <= 3; k++) step(1'b1, k);
    check("ramp_period", period, 7);

    // Randomized square waves, thresholds, gaps and enable drops.
    for (int it = 0; it < 30; it++) begin
      cr_hysteresis = SW'($urandom_range(0, 600)) ;
      if ($urandom_range(0, 3) == 0) restart();
      square($urandom_range(1, 12), $urandom_range(2, 6), $urandom_range(1, 3),
             $urandom_range(0, 2000), $urandom_range(0, 150), 1'($urandom_range(0, 1)));
    end

    idle_cycles(5);
    check("queue_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
